// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with a registered one-cycle
// match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1010,
  parameter int unsigned DEF_LEN = 4,
  parameter logic        DEF_OVL = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         out,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(MAX_LEN+1)-1:0] cur_len
);

  localparam int unsigned LW = $clog2(MAX_LEN+1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_hist_nx;
  logic [LW-1:0]      w_fill_nx;
  logic [MAX_LEN-1:0] w_mask;
  logic [LW-1:0]      w_len_clamped;
  logic               w_match;

  always_comb begin
    w_hist_nx = {r_hist[MAX_LEN-2:0], in};
    w_fill_nx = (r_fill == MAX_L) ? r_fill : r_fill + LW'(1);
    // Only the low r_len bits of pattern and history take part in the compare.
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
    w_match = (w_fill_nx >= r_len) && (((w_hist_nx ^ r_pat) & w_mask) == '0);
  end

  always_comb begin
    w_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      w_len_clamped = LW'(1);
    end else if (cfg_len > MAX_L) begin
      w_len_clamped = MAX_L;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= DEF_PAT;
      r_len  <= LW'(DEF_LEN);
      r_ovl  <= DEF_OVL;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= w_len_clamped;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else if (in_valid) begin
      r_hist <= w_hist_nx;
      r_fill <= (w_match && !r_ovl) ? '0 : w_fill_nx;
      r_out  <= w_match;
    end else begin
      r_out  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      r_cnt <= '0;
    end else if (!cfg_load && in_valid && w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out         = r_out;
  assign match_count = r_cnt;
  assign cur_len     = r_len;

endmodule
